// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the BCD stopwatch engine.
package stopwatch_pkg;

    typedef enum logic [0:0] {
        SW_STOPPED = 1'b0,
        SW_RUNNING = 1'b1
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    // Nibble i holds the maximum value of digit i (99.99-style cascade: 9,9,5,9).
    localparam logic [31:0] DEFAULT_MAX_VEC = 32'h0000_9599;

endpackage

// File: rtl/bcd_stopwatch_core_tick_prescaler.sv
// Tick prescaler: counts 0..DIV-1 while enabled, holds while disabled,
// and flags the count step in the same cycle the terminal value is reached.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic step_o
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] r_pre;

    // The step must take effect on the same edge as the terminal count, so it is combinational.
    assign step_o = en & (r_pre == LAST);

    // Prescaler count: cleared synchronously, wraps on step, frozen while not enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= {PW{1'b0}};
        end else if (clear) begin
            r_pre <= {PW{1'b0}};
        end else if (step_o) begin
            r_pre <= {PW{1'b0}};
        end else if (en) begin
            r_pre <= r_pre + ONE;
        end else begin
            r_pre <= r_pre;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// BCD stopwatch engine: prescaled tick, cascaded BCD digits with per-digit
// modulus, start/stop, lap freeze, up/down count, wrap or saturate-and-stop.
module bcd_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int          CLK_HZ     = 100_000_000,
    parameter int          TICK_HZ    = 100,
    parameter int          NUM_DIGITS = 4,
    parameter logic [31:0] MAX_VEC    = DEFAULT_MAX_VEC,
    parameter bit          WRAP       = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_stop,
    input  logic                    lap,
    input  logic                    clear,
    input  logic                    down,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic                    running_o,
    output logic                    lap_o,
    output logic                    tick_o,
    output logic                    ovf_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = 4 * NUM_DIGITS;

    sw_state_e       r_state;
    sw_state_e       w_state_nxt;
    logic [DW-1:0]   r_live;
    logic [DW-1:0]   r_snap;
    logic [DW-1:0]   r_disp;
    logic [DW-1:0]   w_live_step;
    logic [DW-1:0]   w_live_nxt;
    logic [DW-1:0]   w_snap_nxt;
    logic            r_lap;
    logic            r_ovf;
    logic            r_tick;
    logic            r_running;
    logic            w_lap_nxt;
    logic            w_ovf_nxt;
    logic            w_run;
    logic            w_pre_step;
    logic            w_step;
    logic            w_overflow;
    logic [NUM_DIGITS:0] w_cy;

    assign w_run = (r_state == SW_RUNNING);

    tick_prescaler #(
        .DIV    (DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .en     (w_run),
        .step_o (w_pre_step)
    );

    // Clear outranks a count step landing on the same edge.
    assign w_step  = w_pre_step & ~clear;
    assign w_cy[0] = w_step;

    // Digit chain: w_cy carries (up) or borrows (down) from digit g into g+1.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_t w_max;
        bcd_t w_cur;
        logic w_at_end;

        assign w_max    = MAX_VEC[4*g +: 4];
        assign w_cur    = r_live[4*g +: 4];
        assign w_at_end = down ? (w_cur == 4'd0) : (w_cur == w_max);
        assign w_cy[g+1] = w_cy[g] & w_at_end;
        assign w_live_step[4*g +: 4] = !w_cy[g] ? w_cur :
                                       w_at_end ? (down ? w_max : 4'd0) :
                                       down     ? (w_cur - 4'd1) : (w_cur + 4'd1);
    end

    // A carry out of the last digit means every digit was already at its limit.
    assign w_overflow = w_cy[NUM_DIGITS];

    // Next-state for FSM, live count, lap snapshot and overflow flag.
    always_comb begin
        w_state_nxt = r_state;
        w_live_nxt  = r_live;
        w_snap_nxt  = r_snap;
        w_lap_nxt   = r_lap;
        w_ovf_nxt   = r_ovf;
        if (clear) begin
            w_state_nxt = SW_STOPPED;
            w_live_nxt  = {DW{1'b0}};
            w_snap_nxt  = {DW{1'b0}};
            w_lap_nxt   = 1'b0;
            w_ovf_nxt   = 1'b0;
        end else begin
            if (w_step && !(w_overflow && !WRAP)) begin
                w_live_nxt = w_live_step;
            end else begin
                w_live_nxt = r_live;
            end
            w_ovf_nxt = r_ovf | w_overflow;
            case (r_state)
                SW_STOPPED: begin
                    if (start_stop) begin
                        w_state_nxt = SW_RUNNING;
                    end else begin
                        w_state_nxt = SW_STOPPED;
                    end
                end
                SW_RUNNING: begin
                    if ((w_overflow && !WRAP) || start_stop) begin
                        w_state_nxt = SW_STOPPED;
                    end else begin
                        w_state_nxt = SW_RUNNING;
                    end
                end
                default: begin
                    w_state_nxt = SW_STOPPED;
                end
            endcase
            // Snapshot takes the value after any step on this same edge.
            if (lap && r_lap) begin
                w_lap_nxt = 1'b0;
            end else if (lap && w_run) begin
                w_lap_nxt  = 1'b1;
                w_snap_nxt = w_live_nxt;
            end else begin
                w_lap_nxt  = r_lap;
                w_snap_nxt = r_snap;
            end
        end
    end

    // State and registered outputs; display mux is registered from next-state values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= SW_STOPPED;
            r_live    <= {DW{1'b0}};
            r_snap    <= {DW{1'b0}};
            r_disp    <= {DW{1'b0}};
            r_lap     <= 1'b0;
            r_ovf     <= 1'b0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_live    <= w_live_nxt;
            r_snap    <= w_snap_nxt;
            r_disp    <= w_lap_nxt ? w_snap_nxt : w_live_nxt;
            r_lap     <= w_lap_nxt;
            r_ovf     <= w_ovf_nxt;
            r_tick    <= w_step;
            r_running <= (w_state_nxt == SW_RUNNING);
        end
    end

    assign digits_o  = r_disp;
    assign running_o = r_running;
    assign lap_o     = r_lap;
    assign tick_o    = r_tick;
    assign ovf_o     = r_ovf;

endmodule
